// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file constants, arbiter state encoding and write-entry type
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    ARB_NORMAL    = 1'b0,
    ARB_DRAIN_WAW = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
    logic [DATA_W-1:0]     pc;
  } wr_entry_t;

  // Register zero is hardwired, so it never contributes a pending bit.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = (addr != REG_ZERO);
    return v;
  endfunction

endpackage

// File: rtl/wr_fifo.sv
// rtl/wr_fifo.sv - circular queue of deferred GRF writes with per-entry valid/address view
module wr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                push,
  input  wr_entry_t                           push_entry,
  input  logic                                pop,
  output wr_entry_t                           head,
  output logic [$clog2(DEPTH):0]              count,
  output logic                                full,
  output logic [DEPTH-1:0]                    entry_valid,
  output logic [DEPTH-1:0]                    head_sel,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr
);

  localparam int PW = $clog2(DEPTH);

  wr_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     cnt;
  logic            do_push;
  logic            do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt != '0);
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < cnt;
      head_sel[i]    = (rd_ptr == PW'(i));
      entry_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/grf_write_arbiter.sv
// rtl/grf_write_arbiter.sv - shares the GRF write port between the W stage and a queued multi-cycle writer
module grf_write_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_we,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic [DATA_W-1:0]     a_pc,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  input  logic [DATA_W-1:0]     b_pc,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   pending_mask,
  output logic [REG_ADDR_W-1:0] grf_a3,
  output logic [DATA_W-1:0]     grf_wd,
  output logic [DATA_W-1:0]     grf_wpc
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  arb_state_t                       state;
  logic [CW-1:0]                    starve_cnt;
  wr_entry_t                        head;
  logic [$clog2(DEPTH):0]           count;
  logic                             full;
  logic                             empty;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0]                 head_sel;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entry_addr;
  logic [NUM_REGS-1:0]              mask;
  logic                             a_req;
  logic                             b_push;
  logic                             conflict;
  logic                             starve;
  logic                             grant_a;
  logic                             grant_b;
  logic                             keep_drain;

  wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (b_push),
    .push_entry  ('{addr: b_addr, data: b_data, pc: b_pc}),
    .pop         (grant_b),
    .head        (head),
    .count       (count),
    .full        (full),
    .entry_valid (entry_valid),
    .head_sel    (head_sel),
    .entry_addr  (entry_addr)
  );

  assign empty    = (count == '0);
  assign a_req    = reset && a_we && (a_addr != REG_ZERO);
  assign b_ready  = reset && !full;
  assign b_push   = b_valid && b_ready && (b_addr != REG_ZERO);
  assign starve   = (starve_cnt == CW'(MAX_WAIT)) && !empty;
  assign conflict = a_req && mask[a_addr];

  always_comb begin
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) mask = mask | reg_onehot(entry_addr[i]);
    end
    pending_mask = reset ? mask : '0;
  end

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    stall   = 1'b0;
    if (reset) begin
      if (state == ARB_DRAIN_WAW) begin
        stall   = 1'b1;
        grant_b = !empty;
      end else if (starve || conflict) begin
        stall   = 1'b1;
        grant_b = 1'b1;
      end else if (a_req) begin
        grant_a = 1'b1;
      end else begin
        grant_b = !empty;
      end
    end
  end

  // Drain continues while some entry other than the one leaving now, or the
  // entry arriving now, still targets the stalled W-stage destination.
  always_comb begin
    keep_drain = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == a_addr) && !(grant_b && head_sel[i]))
        keep_drain = 1'b1;
    end
    if (b_push && (b_addr == a_addr)) keep_drain = 1'b1;
    if (!a_req) keep_drain = 1'b0;
  end

  always_comb begin
    grf_a3  = '0;
    grf_wd  = '0;
    grf_wpc = '0;
    if (grant_a) begin
      grf_a3  = a_addr;
      grf_wd  = a_data;
      grf_wpc = a_pc;
    end else if (grant_b) begin
      grf_a3  = head.addr;
      grf_wd  = head.data;
      grf_wpc = head.pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ARB_NORMAL;
      starve_cnt <= '0;
    end else begin
      case (state)
        ARB_NORMAL:    if (!starve && conflict && keep_drain) state <= ARB_DRAIN_WAW;
        ARB_DRAIN_WAW: if (!keep_drain) state <= ARB_NORMAL;
        default:       state <= ARB_NORMAL;
      endcase
      if (grant_b || empty)
        starve_cnt <= '0;
      else if (grant_a && (starve_cnt != CW'(MAX_WAIT)))
        starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb/tb_grf_write_arbiter.sv - directed-vector scoreboard bench for grf_write_arbiter
module tb_grf_write_arbiter;

  logic        clk;
  logic        reset;
  logic        a_we;
  logic [4:0]  a_addr;
  logic [31:0] a_data;
  logic [31:0] a_pc;
  logic        b_valid;
  logic        b_ready;
  logic [4:0]  b_addr;
  logic [31:0] b_data;
  logic [31:0] b_pc;
  logic        stall;
  logic [31:0] pending_mask;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_wpc;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] p;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks   = 0;
  int   failures = 0;

  grf_write_arbiter #(.DEPTH(4), .MAX_WAIT(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .a_we         (a_we),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_pc         (a_pc),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_pc         (b_pc),
    .stall        (stall),
    .pending_mask (pending_mask),
    .grf_a3       (grf_a3),
    .grf_wd       (grf_wd),
    .grf_wpc      (grf_wpc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pc_of(input logic [31:0] d);
    return d ^ 32'h0000_2234;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Every cycle with a GRF write must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (grf_a3 != 5'd0 || grf_wd != 32'd0 || grf_wpc != 32'd0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL grf_unexpected got a3=%0d wd=%h wpc=%h want=no write", grf_a3, grf_wd, grf_wpc);
      end else begin
        e = exp_q.pop_front();
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, e.a});
        chk("grf_wd", grf_wd, e.d);
        chk("grf_wpc", grf_wpc, e.p);
      end
    end
  end

  task automatic cyc(input logic awe, input logic [4:0] aa, input logic [31:0] ad,
                     input logic bv, input logic [4:0] ba, input logic [31:0] bd,
                     input logic xs, input logic xr, input logic [31:0] xm,
                     input logic xw, input logic [4:0] xa, input logic [31:0] xd);
    exp_t n;
    @(posedge clk);
    #1;
    reset = 1'b1;
    a_we = awe; a_addr = aa; a_data = ad; a_pc = pc_of(ad);
    b_valid = bv; b_addr = ba; b_data = bd; b_pc = pc_of(bd);
    if (xw) begin
      n.a = xa; n.d = xd; n.p = pc_of(xd);
      exp_q.push_back(n);
    end
    @(negedge clk);
    chk("stall", {31'd0, stall}, {31'd0, xs});
    chk("b_ready", {31'd0, b_ready}, {31'd0, xr});
    chk("pending_mask", pending_mask, xm);
  endtask

  initial begin
    reset = 1'b0;
    a_we = 1'b1; a_addr = 5'd8; a_data = 32'h1234; a_pc = pc_of(32'h1234);
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h0; b_pc = 32'h0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_b_ready", {31'd0, b_ready}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      chk("rst_mask", pending_mask, 32'd0);
    end

    // pass-through and simple B path
    cyc(1, 8, 32'h1234,     0, 0, 0,            0, 1, 32'h0,        1, 8, 32'h1234);
    cyc(0, 0, 0,            1, 9, 32'hAAAA,     0, 1, 32'h0,        0, 0, 0);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h200,      1, 9, 32'hAAAA);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,        0, 0, 0);

    // fill, backpressure, starvation-forced pop, held 5th push, drain
    cyc(1, 1, 32'hA001,     1, 20, 32'hB014,    0, 1, 32'h0000_0000, 1, 1, 32'hA001);
    cyc(1, 2, 32'hA002,     1, 21, 32'hB015,    0, 1, 32'h0010_0000, 1, 2, 32'hA002);
    cyc(1, 3, 32'hA003,     1, 22, 32'hB016,    0, 1, 32'h0030_0000, 1, 3, 32'hA003);
    cyc(1, 1, 32'hA004,     1, 23, 32'hB017,    0, 1, 32'h0070_0000, 1, 1, 32'hA004);
    cyc(1, 2, 32'hA005,     1, 24, 32'hB018,    0, 0, 32'h00F0_0000, 1, 2, 32'hA005);
    cyc(1, 3, 32'hA006,     1, 24, 32'hB018,    0, 0, 32'h00F0_0000, 1, 3, 32'hA006);
    cyc(1, 1, 32'hA007,     1, 24, 32'hB018,    0, 0, 32'h00F0_0000, 1, 1, 32'hA007);
    cyc(1, 2, 32'hA008,     1, 24, 32'hB018,    0, 0, 32'h00F0_0000, 1, 2, 32'hA008);
    cyc(1, 3, 32'hA009,     1, 24, 32'hB018,    0, 0, 32'h00F0_0000, 1, 3, 32'hA009);
    cyc(1, 1, 32'hA00A,     1, 24, 32'hB018,    1, 0, 32'h00F0_0000, 1, 20, 32'hB014);
    cyc(1, 1, 32'hA00A,     1, 24, 32'hB018,    0, 1, 32'h00E0_0000, 1, 1, 32'hA00A);
    cyc(0, 0, 0,            0, 0, 0,            0, 0, 32'h01E0_0000, 1, 21, 32'hB015);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h01C0_0000, 1, 22, 32'hB016);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0180_0000, 1, 23, 32'hB017);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0100_0000, 1, 24, 32'hB018);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,         0, 0, 0);

    // starvation: one queued entry, A busy every cycle
    cyc(0, 0, 0,            1, 6, 32'hB006,     0, 1, 32'h0,  0, 0, 0);
    for (int i = 1; i <= 8; i++)
      cyc(1, 5, 32'hA050 + i, 0, 0, 0,          0, 1, 32'h40, 1, 5, 32'hA050 + i);
    cyc(1, 5, 32'hA059,     0, 0, 0,            1, 1, 32'h40, 1, 6, 32'hB006);
    cyc(1, 5, 32'hA059,     0, 0, 0,            0, 1, 32'h0,  1, 5, 32'hA059);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,  0, 0, 0);

    // WAW: queued 10, 11, 10 must all land before the W-stage write to 10
    cyc(1, 2, 32'hA101,     1, 10, 32'hB10A,    0, 1, 32'h0,   1, 2, 32'hA101);
    cyc(1, 2, 32'hA102,     1, 11, 32'hB10B,    0, 1, 32'h400, 1, 2, 32'hA102);
    cyc(1, 2, 32'hA103,     1, 10, 32'hB10C,    0, 1, 32'hC00, 1, 2, 32'hA103);
    cyc(1, 10, 32'hA104,    0, 0, 0,            1, 1, 32'hC00, 1, 10, 32'hB10A);
    cyc(1, 10, 32'hA104,    0, 0, 0,            1, 1, 32'hC00, 1, 11, 32'hB10B);
    cyc(1, 10, 32'hA104,    0, 0, 0,            1, 1, 32'h400, 1, 10, 32'hB10C);
    cyc(1, 10, 32'hA104,    0, 0, 0,            0, 1, 32'h0,   1, 10, 32'hA104);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,   0, 0, 0);

    // register zero on the B side is accepted and dropped
    cyc(0, 0, 0,            1, 0, 32'hB000,     0, 1, 32'h0,   0, 0, 0);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,   0, 0, 0);

    // reset while draining discards the queue
    cyc(1, 2, 32'hA201,     1, 12, 32'hB20C,    0, 1, 32'h0,    1, 2, 32'hA201);
    cyc(1, 2, 32'hA202,     1, 13, 32'hB20D,    0, 1, 32'h1000, 1, 2, 32'hA202);
    cyc(1, 2, 32'hA203,     1, 12, 32'hB20E,    0, 1, 32'h3000, 1, 2, 32'hA203);
    cyc(1, 12, 32'hA204,    0, 0, 0,            1, 1, 32'h3000, 1, 12, 32'hB20C);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    chk("mid_rst_a3", {27'd0, grf_a3}, 32'd0);
    chk("mid_rst_mask", pending_mask, 32'd0);
    chk("mid_rst_b_ready", {31'd0, b_ready}, 32'd0);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,    0, 0, 0);
    cyc(1, 12, 32'hA204,    0, 0, 0,            0, 1, 32'h0,    1, 12, 32'hA204);
    cyc(0, 0, 0,            0, 0, 0,            0, 1, 32'h0,    0, 0, 0);

    @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/grf_write_arbiter.md
Name: grf_write_arbiter

Overview:
- Shares the single GRF write port (A3/WD/W_PC) between two writers.
- Writer A is the pipeline W stage. It has priority and is passed through with zero latency.
- Writer B is a multi-cycle source (MDU result, late load return). It is handshaked into a small FIFO.
- The block provides WAW ordering, a starvation guard and a pending-write mask for the hazard unit.

Parameters:
- DEPTH, 4, B-side FIFO entries; power of two, at least 2.
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO may be denied before a forced drain.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low; registers clear on a clk edge while reset==0.
- a_we  in  1  pipeline write request this cycle.
- a_addr  in  5  pipeline destination register.
- a_data  in  32  pipeline write data.
- a_pc  in  32  PC of the writing instruction.
- b_valid  in  1  B-side request.
- b_ready  out  1  B-side accept.
- b_addr  in  5  B destination register.
- b_data  in  32  B write data.
- b_pc  in  32  B instruction PC.
- stall  out  1  freeze the pipeline; W stage re-presents the same a_* next cycle.
- pending_mask  out  32  bit r set if any FIFO entry targets register r; bit 0 is always 0.
- grf_a3  out  5  to GRF A3; 0 means no write.
- grf_wd  out  32  to GRF WD.
- grf_wpc  out  32  to GRF W_PC.

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO emptied, starve counter 0, FSM to NORMAL.
  - While reset is low: b_ready=0, stall=0, grf_a3=0, grf_wd=0, grf_wpc=0, pending_mask=0.
  - Reset mid-drain discards all queued B writes.
- B handshake:
  - Transfer when b_valid && b_ready.
  - b_ready = !full (registered state only; no same-cycle pop-to-push pass-through).
  - b_addr==0 is accepted and dropped, never enqueued.
  - Push and pop in the same cycle on a non-full FIFO are both legal; count is unchanged.
- FIFO: circular, pointers wrap modulo DEPTH, count width clog2(DEPTH)+1. Head is exposed combinationally.
- Outputs to GRF:
  - A-grant: grf_* = {a_addr, a_data, a_pc} in the same cycle, zero latency.
  - B-grant: grf_* = FIFO head; pop on that edge.
  - No grant: grf_a3=0, grf_wd=0, grf_wpc=0.
  - a_we with a_addr==0 counts as no request.
  - B data reaches GRF at the earliest 1 cycle after acceptance.
- FSM NORMAL:
  - Grant A if a_we and there is no conflict. Otherwise grant B if the FIFO is non-empty.
  - Conflict: a_we && pending_mask[a_addr]. Go to DRAIN_WAW with stall=1, and grant B this cycle.
  - Starvation: the counter increments each cycle the FIFO is non-empty and A is granted. It clears on any B grant or when the FIFO is empty.
  - When the counter == MAX_WAIT: stall=1, grant B, A ignored this cycle, counter cleared. This is a one-cycle event; stay in NORMAL.
- FSM DRAIN_WAW:
  - stall=1 and grant B each cycle.
  - Return to NORMAL on the edge where pending_mask[a_addr] would clear, i.e. the last matching entry is popped and no new matching entry is pushed the same cycle.
  - The next cycle grants A normally.
- pending_mask:
  - OR of decoded addresses of valid entries, computed from the registered FIFO contents.
  - A push becomes visible the cycle after.
- Ordering: the pipeline never overtakes an older queued write to the same register. Writes to different registers may complete out of order.
- Simultaneous events: A request + B push + B pop in one cycle: A is granted, the B push is enqueued, no pop occurs.

Decomposition:
- Shared package (cpu_pkg):
  - constants REG_ADDR_W=5, DATA_W=32, REG_ZERO=5'd0.
  - FSM state encoding ARB_NORMAL, ARB_DRAIN_WAW.
- One natural sub-module: wr_fifo, a parameterised DEPTH x (5+32+32) FIFO with a count output and a per-entry valid/address view for building the mask.

Test Plan:
1. Reset and pass-through. Hold reset=0 for 2 cycles, then release. Drive a_we=1, a_addr=8, a_data=0x1234, a_pc=0x3000. Expect b_ready=0 during reset, then the same-cycle grf_a3=8, grf_wd=0x1234, grf_wpc=0x3000, stall=0.
2. B path. a_we=0; push b_addr=9, b_data=0xAAAA. Expect pending_mask=0x200 the next cycle and grf_a3=9, grf_wd=0xAAAA one cycle after acceptance, then the mask returns to 0.
3. Full and backpressure. With a_we=1 continuously to regs 1-3, push 4 B writes. Expect b_ready=0 after the 4th. A 5th push is held until a pop, with no loss or duplication.
4. Starvation. FIFO holds 1 entry; a_we=1 to reg 5 every cycle. Expect stall=1 and a B grant on the 9th cycle (MAX_WAIT=8), with the A write re-presented and written the following cycle.
5. WAW. Queue B writes to regs 10, 11, 10. Then present a_we to reg 10. Expect stall high for 3 cycles while writing 10, 11, 10 in order, then the A write to 10 lands last.
6. Zero register and mid-drain reset. A b_addr=0 push is accepted with the mask unchanged and no GRF write. Assert reset during DRAIN_WAW: FIFO empties, stall=0 and grf_a3=0 the next cycle.
